// File: rtl/aes_arb_pkg.sv
// aes_arb_pkg: shared types and constants for the AES request arbiter.
// Holds the FSM state encoding, the AES block width, default timing
// parameters and a small modulo-add helper used by the round-robin logic.
package aes_arb_pkg;

  // Width of one AES plaintext, key or ciphertext block.
  localparam int AES_BLK_W = 128;

  // Default number of idle cycles on AES_en between two jobs.
  localparam int AES_ARB_GAP_CYCLES = 2;

  // Default RUN-state watchdog limit (only used with AES_ARB_TIMEOUT_EN).
  localparam int AES_ARB_TIMEOUT_CYCLES = 64;

  // Arbiter FSM states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_RESP = 3'd3,
    ST_GAP  = 3'd4
  } aes_arb_state_t;

  // (base + step) mod num, assuming base < num and step <= num.
  // Avoids a real modulo so the picker stays a plain adder/compare.
  function automatic int rr_wrap(input int base, input int step, input int num);
    int sum;
    sum = base + step;
    if (sum >= num) begin
      sum = sum - num;
    end
    return sum;
  endfunction

endpackage

// File: rtl/aes_rr_pick.sv
// aes_rr_pick: combinational round-robin priority picker.
// Searches req_valid starting at rr_ptr and wrapping around; the first
// valid requester found wins. Outputs a one-hot grant, the winner index
// and an any-valid flag.
module aes_rr_pick
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               any
);

  // rot_idx[k] is the requester index examined at search offset k from
  // the pointer; rot_valid[k] is that requester's valid bit.
  logic [IDW-1:0]     rot_idx [NUM_REQ];
  logic [NUM_REQ-1:0] rot_valid;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign rot_idx[gi]   = IDW'(rr_wrap(int'(rr_ptr), gi, NUM_REQ));
      assign rot_valid[gi] = req_valid[rot_idx[gi]];
    end
  endgenerate

  // Priority search over the rotated vector: lowest offset wins, so the
  // loop runs from the highest offset down and the last hit sticks.
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        any       = 1'b1;
        grant_idx = rot_idx[k];
      end
    end
  end

  assign grant = any ? (NUM_REQ'(1) << grant_idx) : '0;

endmodule

// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: round-robin scheduler sharing one AES_top core between
// NUM_REQ requesters. One block/key pair is in flight at a time; the result
// is returned tagged with the requester index over a backpressured port.
//
// Optional feature macro: AES_ARB_TIMEOUT_EN
//   defined   -> RUN-state watchdog; a job that sees no core valid within
//                TIMEOUT_CYCLES is answered with resp_err = 1, resp_data = 0.
//   undefined -> no watchdog, resp_err is tied low, RUN waits indefinitely.
module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int GAP_CYCLES     = AES_ARB_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = AES_ARB_TIMEOUT_CYCLES
) (
  input  logic                           AES_clk,
  input  logic                           AES_rst,
  // requester side
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*AES_BLK_W-1:0]   req_data,
  input  logic [NUM_REQ*AES_BLK_W-1:0]   req_key,
  // response side
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [IDW-1:0]                 resp_id,
  output logic [AES_BLK_W-1:0]           resp_data,
  output logic                           resp_err,
  output logic                           busy,
  // AES core side
  output logic                           AES_en,
  output logic [AES_BLK_W-1:0]           AES_data_in,
  output logic [AES_BLK_W-1:0]           AES_key_in,
  input  logic [AES_BLK_W-1:0]           AES_data_out,
  input  logic                           AES_data_out_valid
);

  // Elaboration-time parameter sanity: the gap counter is 4 bits wide and
  // a zero-length watchdog would never let a job run.
  generate
    if (GAP_CYCLES < 1 || GAP_CYCLES > 15 || TIMEOUT_CYCLES < 1 ||
        NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_cfg
      $error("aes_req_arbiter: parameter out of range");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------
  aes_arb_state_t        state_reg;
  aes_arb_state_t        state_next;
  logic [IDW-1:0]        rr_ptr_reg;
  logic [3:0]            gap_cnt_reg;
  logic [AES_BLK_W-1:0]  data_in_reg;
  logic [AES_BLK_W-1:0]  key_in_reg;
  logic [AES_BLK_W-1:0]  resp_data_reg;
  logic [IDW-1:0]        resp_id_reg;
  logic                  en_reg;
  logic                  resp_valid_reg;
  logic                  busy_reg;

  // Picker results and decoded events
  logic [NUM_REQ-1:0]    pick_grant;
  logic [IDW-1:0]        pick_idx;
  logic                  pick_any;
  logic                  accept;
  logic                  core_done;
  logic                  timeout_hit;
  logic                  gap_done;

  // Per-requester views of the packed data/key buses.
  logic [AES_BLK_W-1:0]  req_data_arr [NUM_REQ];
  logic [AES_BLK_W-1:0]  req_key_arr  [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_data_arr[gi] = req_data[gi*AES_BLK_W +: AES_BLK_W];
      assign req_key_arr[gi]  = req_key[gi*AES_BLK_W +: AES_BLK_W];
    end
  endgenerate

  aes_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_reg),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  // Only the winner sees ready, only in IDLE, and never while reset is
  // being applied (the picker alone would otherwise grant in that cycle).
  assign req_ready = (state_reg == ST_IDLE && !AES_rst && pick_any) ?
                     pick_grant : {NUM_REQ{1'b0}};
  assign accept    = |(req_valid & req_ready);
  assign core_done = (state_reg == ST_RUN) && AES_data_out_valid;
  assign gap_done  = (gap_cnt_reg == 4'(GAP_CYCLES - 1));

  // ---------------------------------------------------------------------
  // Optional RUN-state watchdog
  // ---------------------------------------------------------------------
`ifdef AES_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_reg;
  logic            resp_err_reg;

  // A real core valid on the last allowed cycle still wins over the timeout.
  assign timeout_hit = (state_reg == ST_RUN) && !AES_data_out_valid &&
                       (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));

  // Count RUN cycles from 0 and flag a watchdog abort until the next accept.
  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      wd_cnt_reg   <= '0;
      resp_err_reg <= 1'b0;
    end else begin
      if (state_reg == ST_LOAD) begin
        wd_cnt_reg <= '0;
      end else if (state_reg == ST_RUN) begin
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
      end
      if (accept) begin
        resp_err_reg <= 1'b0;
      end else if (timeout_hit) begin
        resp_err_reg <= 1'b1;
      end
    end
  end

  assign resp_err = resp_err_reg;
`else
  assign timeout_hit = 1'b0;
  assign resp_err    = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept)                   state_next = ST_LOAD;
      ST_LOAD:                               state_next = ST_RUN;
      ST_RUN:  if (core_done || timeout_hit) state_next = ST_RESP;
      ST_RESP: if (resp_ready)               state_next = ST_GAP;
      ST_GAP:  if (gap_done)                 state_next = ST_IDLE;
      default:                               state_next = ST_IDLE;
    endcase
  end

  // State register plus all registered outputs; reset aborts any job.
  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state_reg      <= ST_IDLE;
      rr_ptr_reg     <= '0;
      gap_cnt_reg    <= '0;
      data_in_reg    <= '0;
      key_in_reg     <= '0;
      resp_data_reg  <= '0;
      resp_id_reg    <= '0;
      en_reg         <= 1'b0;
      resp_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != ST_IDLE);
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            data_in_reg <= req_data_arr[pick_idx];
            key_in_reg  <= req_key_arr[pick_idx];
            resp_id_reg <= pick_idx;
            rr_ptr_reg  <= IDW'(rr_wrap(int'(pick_idx), 1, NUM_REQ));
          end
        end
        ST_LOAD: begin
          en_reg <= 1'b1;
        end
        ST_RUN: begin
          if (core_done) begin
            resp_data_reg  <= AES_data_out;
            en_reg         <= 1'b0;
            resp_valid_reg <= 1'b1;
          end else if (timeout_hit) begin
            resp_data_reg  <= '0;
            en_reg         <= 1'b0;
            resp_valid_reg <= 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_reg <= 1'b0;
            gap_cnt_reg    <= '0;
          end
        end
        ST_GAP: begin
          gap_cnt_reg <= gap_cnt_reg + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign AES_en      = en_reg;
  assign AES_data_in = data_in_reg;
  assign AES_key_in  = key_in_reg;
  assign resp_valid  = resp_valid_reg;
  assign resp_id     = resp_id_reg;
  assign resp_data   = resp_data_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb_aes_req_arbiter: scoreboard bench for aes_req_arbiter with an AES core
// stub (valid 11 cycles after AES_en rises, out = data ^ key).
// Build with +define+AES_ARB_TIMEOUT_EN to include the watchdog scenario.
module tb_aes_req_arbiter;

  localparam int NUM_REQ = 2;
  localparam int IDW     = 1;
  localparam int GAP     = 2;
  localparam int TMO     = 64;

  localparam logic [127:0] D0 = 128'h0000007a_00000000_00000000_00000000;
  localparam logic [127:0] K0 = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
  localparam logic [127:0] E0 = 128'haa2bdb3a_bff6a5e8_caa9ba3e_bc1e2acc;
  localparam logic [127:0] D1 = 128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [127:0] K1 = 128'hffffffff_ffffffff_ffffffff_ffffffff;
  localparam logic [127:0] E1 = 128'hfedcba98_76543210_01234567_89abcdef;

  logic                     AES_clk = 1'b0;
  logic                     AES_rst = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*128-1:0]   req_data = '0;
  logic [NUM_REQ*128-1:0]   req_key = '0;
  logic                     resp_valid;
  logic                     resp_ready = 1'b1;
  logic [IDW-1:0]           resp_id;
  logic [127:0]             resp_data;
  logic                     resp_err;
  logic                     busy;
  logic                     AES_en;
  logic [127:0]             AES_data_in;
  logic [127:0]             AES_key_in;
  logic [127:0]             AES_data_out;
  logic                     AES_data_out_valid;

  always #5 AES_clk = ~AES_clk;

  aes_req_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .IDW            (IDW),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .AES_clk            (AES_clk),
    .AES_rst            (AES_rst),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_data           (req_data),
    .req_key            (req_key),
    .resp_valid         (resp_valid),
    .resp_ready         (resp_ready),
    .resp_id            (resp_id),
    .resp_data          (resp_data),
    .resp_err           (resp_err),
    .busy               (busy),
    .AES_en             (AES_en),
    .AES_data_in        (AES_data_in),
    .AES_key_in         (AES_key_in),
    .AES_data_out       (AES_data_out),
    .AES_data_out_valid (AES_data_out_valid)
  );

  // Core stub: counts cycles since AES_en rose (0 in the first high cycle).
  logic [5:0] stub_cnt  = '0;
  logic       stub_mute = 1'b0;

  always @(posedge AES_clk) begin
    if (!AES_en) stub_cnt <= '0;
    else if (stub_cnt != 6'd63) stub_cnt <= stub_cnt + 6'd1;
  end

  assign AES_data_out_valid = AES_en && (stub_cnt == 6'd11) && !stub_mute;
  assign AES_data_out       = AES_data_in ^ AES_key_in;

  // Scoreboard
  typedef struct {
    logic [IDW-1:0] id;
    logic [127:0]   data;
    logic           err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_resp   = 0;

  int   high_cnt  = 0;
  int   low_cnt   = 0;
  int   last_high = 0;
  int   last_low  = 0;
  logic en_prev   = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  task automatic push_exp(input logic [IDW-1:0] id, input logic [127:0] data, input logic err);
    exp_t e;
    e.id   = id;
    e.data = data;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  // Returns one cycle after the cycle in which req_ready[idx] was seen high.
  task automatic wait_ready(input int idx);
    int n;
    n = 0;
    #1;
    while (!req_ready[idx] && n < 200) begin
      @(posedge AES_clk); #1;
      n++;
    end
    if (!req_ready[idx]) begin
      n_checks++;
      $display("FAIL wait_ready%0d: req_ready=%b required bit high within 200 cycles", idx, req_ready);
    end
    @(posedge AES_clk); #1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge AES_clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL %s: %0d responses pending after %0d cycles, required 0", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  // Monitor: pops the scoreboard on each response handshake, checks the
  // req_ready invariant and measures AES_en high/low run lengths.
  initial begin
    exp_t e;
    logic legal;
    forever begin
      @(negedge AES_clk);
      legal = (req_ready == '0) || ($onehot(req_ready) && !busy && !AES_en);
      chk("req_ready_legal", {127'd0, legal}, 128'd1);
      if (resp_valid && resp_ready) begin
        n_resp++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_resp: id=%0d data=%h required no response", resp_id, resp_data);
        end else begin
          e = exp_q.pop_front();
          $display("resp #%0d: id=%0d data=%h err=%0b", n_resp, resp_id, resp_data, resp_err);
          chk("resp_id", resp_id, e.id);
          chk("resp_data", resp_data, e.data);
          chk("resp_err", resp_err, e.err);
        end
      end
      if (AES_en) begin
        if (!en_prev) begin last_low = low_cnt; low_cnt = 0; end
        high_cnt++;
      end else begin
        if (en_prev) begin last_high = high_cnt; high_cnt = 0; end
        low_cnt++;
      end
      en_prev = AES_en;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    req_data = {D1, D0};
    req_key  = {K1, K0};

    // ---- reset values ----
    repeat (3) begin @(posedge AES_clk); #1; end
    chk("rst_busy", busy, 0);
    chk("rst_en", AES_en, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_data_in", AES_data_in, 0);
    chk("rst_key_in", AES_key_in, 0);
    req_valid = 2'b01;
    #1;
    chk("rst_req_ready", req_ready, 0);

    // ---- single job ----
    AES_rst = 1'b0;
    push_exp(1'b0, E0, 1'b0);
    wait_ready(0);
    chk("t1_data_in", AES_data_in, D0);
    chk("t1_key_in", AES_key_in, K0);
    chk("t1_en_low", AES_en, 0);
    chk("t1_busy", busy, 1);
    req_valid = 2'b00;
    @(posedge AES_clk); #1;
    chk("t2_en_high", AES_en, 1);
    wait_drain(100, "single_drain");
    @(posedge AES_clk); #1;
    chk("single_en_len", last_high, 12);

    // ---- contention from reset release: 0,1,0,1 ----
    AES_rst   = 1'b1;
    req_valid = 2'b11;
    repeat (2) begin @(posedge AES_clk); #1; end
    push_exp(1'b0, E0, 1'b0);
    push_exp(1'b1, E1, 1'b0);
    push_exp(1'b0, E0, 1'b0);
    push_exp(1'b1, E1, 1'b0);
    AES_rst = 1'b0;
    wait_drain(300, "contention_drain");
    req_valid = 2'b00;
    repeat (4) begin @(posedge AES_clk); #1; end

    // ---- backpressure: response held 20 cycles ----
    resp_ready = 1'b0;
    req_valid  = 2'b11;
    push_exp(1'b0, E0, 1'b0);
    n = 0;
    while (!resp_valid && n < 100) begin @(posedge AES_clk); #1; n++; end
    chk("bp_resp_valid_seen", resp_valid, 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge AES_clk); #1;
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_resp_data", resp_data, E0);
      chk("bp_resp_id", resp_id, 0);
      chk("bp_en", AES_en, 0);
      chk("bp_req_ready", req_ready, 0);
    end

    // ---- gap: two back-to-back jobs from requester 1 ----
    push_exp(1'b1, E1, 1'b0);
    push_exp(1'b1, E1, 1'b0);
    req_valid  = 2'b10;
    resp_ready = 1'b1;
    wait_ready(1);
    wait_ready(1);
    req_valid = 2'b00;
    wait_drain(200, "gap_drain");
    n_checks++;
    if (last_low >= 5) n_pass++;
    else $display("FAIL gap_low_len: got %0d required >= 5", last_low);

    // ---- reset mid-RUN ----
    req_valid = 2'b01;
    wait_ready(0);
    req_valid = 2'b00;
    n = 0;
    while (!AES_en && n < 20) begin @(posedge AES_clk); #1; n++; end
    chk("mid_en_rose", AES_en, 1);
    repeat (5) begin @(posedge AES_clk); #1; end
    AES_rst = 1'b1;
    @(posedge AES_clk); #1;
    chk("mid_en", AES_en, 0);
    chk("mid_busy", busy, 0);
    chk("mid_resp_valid", resp_valid, 0);
    chk("mid_resp_data", resp_data, 0);
    chk("mid_resp_id", resp_id, 0);
    chk("mid_resp_err", resp_err, 0);
    chk("mid_data_in", AES_data_in, 0);
    chk("mid_key_in", AES_key_in, 0);
    chk("mid_req_ready", req_ready, 0);
    AES_rst = 1'b0;
    repeat (15) begin @(posedge AES_clk); #1; end
    chk("mid_no_resp", resp_valid, 0);
    req_valid = 2'b11;
    #1;
    n = 0;
    while (req_ready == '0 && n < 20) begin @(posedge AES_clk); #1; n++; end
    chk("post_rst_grant", req_ready, 2'b01);
    push_exp(1'b0, E0, 1'b0);
    @(posedge AES_clk); #1;
    req_valid = 2'b00;
    wait_drain(100, "post_rst_drain");

`ifdef AES_ARB_TIMEOUT_EN
    // ---- watchdog: core never answers ----
    stub_mute = 1'b1;
    req_valid = 2'b10;
    push_exp(1'b1, 128'd0, 1'b1);
    wait_ready(1);
    req_valid = 2'b00;
    wait_drain(300, "wd_drain");
    @(posedge AES_clk); #1;
    chk("wd_en_len", last_high, TMO);
    stub_mute = 1'b0;
    req_valid = 2'b01;
    push_exp(1'b0, E0, 1'b0);
    wait_ready(0);
    chk("wd_err_cleared", resp_err, 0);
    req_valid = 2'b00;
    wait_drain(100, "wd_next_drain");
`endif

    repeat (5) begin @(posedge AES_clk); #1; end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_req_arbiter.md
# aes_req_arbiter

Round-robin scheduler that shares one `AES_top` encryption core between `NUM_REQ` requesters. It accepts one 128-bit block/key pair at a time and drives the core's `AES_en`, `AES_data_in` and `AES_key_in`. It captures `AES_data_out` on `AES_data_out_valid` and returns the result, tagged with the requester index, over a backpressured response port. It sits directly above `AES_top` in the top-level crypto subsystem.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, 2..8.
- `IDW`, 1: width of the requester index; `$clog2(NUM_REQ)`, minimum 1.
- `GAP_CYCLES`, 2: number of cycles `AES_en` stays low between two jobs. Range 1..15.
- `TIMEOUT_CYCLES`, 64: RUN-state watchdog limit. Used only with `AES_ARB_TIMEOUT_EN`.

Ports:
- `AES_clk`, in, 1: single clock. All logic is on the rising edge.
- `AES_rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, NUM_REQ: per-requester request valid.
- `req_ready`, out, NUM_REQ: per-requester accept. At most one bit is high at a time.
- `req_data`, in, NUM_REQ*128: plaintext. Requester i uses bits [128*i+:128].
- `req_key`, in, NUM_REQ*128: key, packed the same way as `req_data`.
- `resp_valid`, out, 1: result available.
- `resp_ready`, in, 1: consumer accepts the result.
- `resp_id`, out, IDW: index of the requester that owns the result.
- `resp_data`, out, 128: ciphertext.
- `resp_err`, out, 1: job aborted by the watchdog.
- `busy`, out, 1: high whenever the state is not IDLE.
- `AES_en`, out, 1: core enable.
- `AES_data_in`, out, 128: core plaintext.
- `AES_key_in`, out, 128: core key.
- `AES_data_out`, in, 128: core result.
- `AES_data_out_valid`, in, 1: core result valid.

## Operation
- States: IDLE, LOAD, RUN, RESP, GAP. All outputs are registered.
- IDLE:
  - The round-robin pick searches `req_valid` starting at pointer `rr_ptr`.
  - `req_ready[g]` is high combinationally for the winner g only.
  - On `req_valid[g] & req_ready[g]`: latch data and key into `AES_data_in`/`AES_key_in`, latch `resp_id` = g, set `rr_ptr` = (g+1) mod NUM_REQ, and go to LOAD.
- LOAD: assert `AES_en`, then go to RUN.
- RUN:
  - `AES_en` stays high. `AES_data_in` and `AES_key_in` stay stable.
  - On the first cycle `AES_data_out_valid` is high: capture `AES_data_out` into `resp_data`, deassert `AES_en`, and go to RESP.
- RESP: `resp_valid` is high and holds `resp_data`, `resp_id` and `resp_err` stable until `resp_ready`. On acceptance, go to GAP.
- GAP: `AES_en` stays low for `GAP_CYCLES` cycles, counted by a 4-bit counter. Then go to IDLE.
- Requests whose `req_valid` is high outside IDLE simply wait. `req_ready` is 0 in every state other than IDLE.
- `AES_data_out_valid` outside RUN is ignored.
- If `resp_ready` is already high when RESP is entered, the handshake completes on that first RESP cycle.

## Timing
- Reset values:
  - State is IDLE and `rr_ptr` = 0.
  - `AES_en`, `AES_data_in`, `AES_key_in`, `resp_valid`, `resp_id`, `resp_data`, `resp_err` and `busy` are all 0.
  - `req_ready` is all 0 during the reset cycle.
- Accept cycle T:
  - T+1: `AES_data_in`/`AES_key_in` are loaded and state is LOAD.
  - T+2: `AES_en` = 1.
- Core valid seen at cycle V → `resp_valid` = 1 and `AES_en` = 0 at V+1.
- Back-to-back throughput: the next `AES_en` rise is no earlier than 2 + GAP_CYCLES + 1 cycles after the `resp_valid` handshake.
- Reset asserted mid-job aborts immediately. On the next edge all outputs return to reset values and no response is emitted. `AES_en` falls in the same cycle as `busy`.

## Configuration
- `AES_ARB_TIMEOUT_EN` defined:
  - A RUN-cycle counter starts at 0 on LOAD→RUN.
  - When it reaches `TIMEOUT_CYCLES` without a core valid, the block deasserts `AES_en` and enters RESP with `resp_err` = 1 and `resp_data` = 0.
  - `resp_err` clears when the next job is accepted.
- Not defined: no counter is built, `resp_err` is tied to 0, and RUN waits indefinitely.

## Structure
- Package `aes_arb_pkg` holds:
  - the state enum `aes_arb_state_t` (IDLE, LOAD, RUN, RESP, GAP);
  - `AES_BLK_W` = 128;
  - default `GAP_CYCLES` and `TIMEOUT_CYCLES` constants.
- One sub-module, `aes_rr_pick`: a combinational round-robin priority picker. Inputs are `req_valid` and `rr_ptr`. Outputs are the one-hot grant, the grant index and `any`.
- The FSM, registers and watchdog live in `aes_req_arbiter`.

## Test plan
All scenarios use a core stub: valid is raised 11 cycles after `AES_en` rises, with out = data ^ key.
- Single job: requester 0 sends data 0000007a_00000000_00000000_00000000 with key aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc. Required: `resp_id` = 0, `resp_data` = aa2bdb3a_bff6a5e8_caa9ba3e_bc1e2acc, and `AES_en` high for exactly 12 cycles.
- Contention: both requesters hold `req_valid` from reset release. Required grant order 0,1,0,1 over 4 jobs, with `req_ready` one-hot in IDLE and 0 elsewhere.
- Backpressure: hold `resp_ready` = 0 for 20 cycles. Required: `resp_valid`, `resp_data` and `resp_id` stay stable, `AES_en` stays 0, and no new `req_ready` is asserted.
- Gap: two back-to-back jobs with GAP_CYCLES = 2. Required: `AES_en` is low for at least 5 cycles between the two high periods.
- Reset mid-RUN: assert `AES_rst` 5 cycles after `AES_en` rises. Required: all outputs are at reset values on the next cycle, no `resp_valid` appears, and the next job is granted to requester 0.
- Watchdog, with `AES_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES = 64: the stub never raises valid. Required: `AES_en` falls after 64 RUN cycles, followed by `resp_valid` with `resp_err` = 1 and `resp_data` = 0.
